mux_pipe: RTL

- Parametrised N:1 data selector with a registered, elastic output stage for the pipelined RISC-V datapath.
- Used for PC-next select, ALU operand forwarding and writeback select.
- The selected word is captured into a 2-entry skid buffer with valid/ready handshakes on both sides, so back-pressure never drops or duplicates data.
- Flush support allows branch/jump squashing.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mux_pipe_if.sv | 30 +++
 rtl/mux_n.sv | 48 ++++
 rtl/mux_pipe.sv | 112 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath types for the pipelined RISC-V core: word type, mux_pipe
// state encoding and the select-width rule used by every N:1 selector.
// Build option: MUX_PIPE_ONEHOT_EN switches selects from binary to one-hot.
package cpu_pkg;

    localparam int DATA_SIZE = 32;

    typedef logic [DATA_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } mux_pipe_state_t;

    // Select width for an N-input selector: one bit per input in one-hot
    // builds, otherwise a binary index (never narrower than one bit).
    function automatic int sel_width(input int n);
`ifdef MUX_PIPE_ONEHOT_EN
        return n;
`else
        return (n > 1) ? $clog2(n) : 1;
`endif
    endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Handshake bundle between a producer, the mux_pipe selector and its consumer.
// master: drives inputs/select/flush/out_ready; slave: the mux_pipe itself.
// sel is NUM_IN bits wide when MUX_PIPE_ONEHOT_EN is defined, else $clog2(NUM_IN).
interface mux_pipe_if #(
    parameter int DATA_SIZE = cpu_pkg::DATA_SIZE,
    parameter int NUM_IN    = 4
);
    localparam int SEL_W = cpu_pkg::sel_width(NUM_IN);

    logic [NUM_IN*DATA_SIZE-1:0] in_data;
    logic [SEL_W-1:0]            sel;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [DATA_SIZE-1:0]        out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        sel_err;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

endinterface

// File: rtl/mux_n.sv
// Combinational N:1 word selector with illegal-select flag (reused unbuffered).
// Latency: 0 cycles. Backpressure: none, pure function of in_data_i/sel_i.
// Ports: in_data_i (flattened inputs), sel_i, data_o (0 on bad select), sel_err_o.
// MUX_PIPE_ONEHOT_EN: sel_i is one-hot; zero or multiple bits set is illegal.
module mux_n #(
    parameter int DATA_SIZE = cpu_pkg::DATA_SIZE,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = cpu_pkg::sel_width(NUM_IN)
) (
    input  logic [NUM_IN*DATA_SIZE-1:0] in_data_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic [DATA_SIZE-1:0]        data_o,
    output logic                        sel_err_o
);

`ifdef MUX_PIPE_ONEHOT_EN
    always_comb begin
        data_o    = '0;
        sel_err_o = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i[k]) begin
                data_o = data_o | in_data_i[k*DATA_SIZE +: DATA_SIZE];
            end
        end
        // OR-ing above is only meaningful for exactly one hot bit.
        if ($countones(sel_i) != 1) begin
            data_o    = '0;
            sel_err_o = 1'b1;
        end
    end
`else
    logic hit;

    always_comb begin
        data_o = '0;
        hit    = 1'b0;
        // Indices >= NUM_IN match nothing, which covers non-power-of-2 NUM_IN.
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = in_data_i[k*DATA_SIZE +: DATA_SIZE];
                hit    = 1'b1;
            end
        end
        sel_err_o = ~hit;
    end
`endif

endmodule

// File: rtl/mux_pipe.sv
// N:1 selector feeding a 2-entry skid buffer (main = head, skid = second).
// Latency: 1 cycle from accept to out_data when empty; strict FIFO order.
// Backpressure: in_ready/out_valid are registers; in_ready drops only in FULL2.
// Ports: clk, rst (sync, active-high), bus (mux_pipe_if.slave).
// MUX_PIPE_ONEHOT_EN selects one-hot sel encoding; buffering is unchanged.
module mux_pipe #(
    parameter int DATA_SIZE = cpu_pkg::DATA_SIZE,
    parameter int NUM_IN    = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_pipe_if.slave    bus
);
    import cpu_pkg::*;

    localparam int SEL_W = sel_width(NUM_IN);

    mux_pipe_state_t      state_q, state_d;
    logic [DATA_SIZE-1:0] main_q, main_d;
    logic [DATA_SIZE-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sel_err_q, sel_err_d;

    logic [DATA_SIZE-1:0] sel_word;
    logic                 sel_bad;
    logic                 accept;
    logic                 drain;

    mux_n #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W)
    ) u_mux_n (
        .in_data_i (bus.in_data),
        .sel_i     (bus.sel),
        .data_o    (sel_word),
        .sel_err_o (sel_bad)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = 1'b0;

        if (bus.flush) begin
            // Same-cycle accept/drain are void: the word is dropped silently.
            state_d = EMPTY;
            main_d  = '0;
        end else begin
            sel_err_d = accept && sel_bad;
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = sel_word;
                        state_d = FULL1;
                    end
                end
                FULL1: begin
                    if (accept && !drain) begin
                        skid_d  = sel_word;
                        state_d = FULL2;
                    end else if (accept && drain) begin
                        main_d = sel_word;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL2: begin
                    // in_ready is low here, so only a drain can move state.
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = FULL1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Handshake outputs follow the next state so they leave as registers.
        in_ready_d  = (state_d != FULL2);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.sel_err   = sel_err_q;

endmodule
